// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_NRD   = 2;

    // Register dump sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } dump_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write and dump signals between a client and regfile_mp.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned NRD   = DEF_NRD
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 hlt;
    logic                 dump_valid;
    logic                 dump_ready;
    logic [AW-1:0]        dump_addr;
    logic [WIDTH-1:0]     dump_data;
    logic                 dump_done;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, hlt, dump_ready,
        input  rd_data, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, hlt, dump_ready,
        output rd_data, dump_valid, dump_addr, dump_data, dump_done
    );

endinterface

// File: rtl/rf_dump_fsm.sv
// Halt-triggered register dump: edge detect, walking pointer and valid/ready handshake.
// Register contents are fetched through the peek_idx/peek_data pair.
module rf_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hlt,
    input  logic             dump_ready,
    output logic [AW-1:0]    peek_idx,
    input  logic [WIDTH-1:0] peek_data,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_done
);

    localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    dump_state_e state;
    logic        hlt_q;
    logic        hlt_edge;

    assign hlt_edge = hlt & ~hlt_q;

    // Register to snapshot on the next load: first entry when idle, else the following one.
    always_comb begin
        peek_idx = (state == IDLE) ? FIRST : dump_addr + AW'(1);
    end

    // Dump sequencer; dump_addr doubles as the walking pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hlt_q      <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            hlt_q <= hlt;
            unique case (state)
                IDLE: begin
                    if (hlt_edge) begin
                        state      <= DUMP;
                        dump_valid <= 1'b1;
                        dump_addr  <= peek_idx;
                        dump_data  <= peek_data;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (dump_addr == LAST) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_addr <= peek_idx;
                            dump_data <= peek_data;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-before-read bypass, optional
// hardwired zero register and a halt-triggered register dump port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = DEF_NRD,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam bit          ZR = (ZERO_REG != 0);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     rd_next [NRD];
    logic [NRD*WIDTH-1:0] rd_q;
    logic                 wr_ok;
    logic [AW-1:0]        peek_idx;
    logic [WIDTH-1:0]     peek_data;

    assign wr_ok = bus.wr_en && !(ZR && bus.wr_addr == '0);

    // Read-side view of storage with the same-edge write forwarded.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            if (ZR && bus.rd_addr[i*AW +: AW] == '0) begin
                rd_next[i] = '0;
            end else if (wr_ok && bus.wr_addr == bus.rd_addr[i*AW +: AW]) begin
                rd_next[i] = bus.wr_data;
            end else begin
                rd_next[i] = mem[bus.rd_addr[i*AW +: AW]];
            end
        end
        if (ZR && peek_idx == '0) begin
            peek_data = '0;
        end else if (wr_ok && bus.wr_addr == peek_idx) begin
            peek_data = bus.wr_data;
        end else begin
            peek_data = mem[peek_idx];
        end
    end

    // Storage array; writes to register 0 are dropped when it is hardwired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem[d] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Registered read ports; a disabled port holds its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (bus.rd_en[i]) begin
                    rd_q[i*WIDTH +: WIDTH] <= rd_next[i];
                end
            end
        end
    end

    assign bus.rd_data = rd_q;

    rf_dump_fsm #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .hlt        (bus.hlt),
        .dump_ready (bus.dump_ready),
        .peek_idx   (peek_idx),
        .peek_data  (peek_data),
        .dump_valid (bus.dump_valid),
        .dump_addr  (bus.dump_addr),
        .dump_data  (bus.dump_data),
        .dump_done  (bus.dump_done)
    );

endmodule
